// File: rtl/zip_sync_buf_if.sv
// Valid/ready/data stream bundle with a lane count and per-lane width.
// The master drives valid/data; the slave drives ready.
interface zip_sync_buf_if #(
  parameter int SIZE  = 1,
  parameter int WIDTH = 8
);
  logic [SIZE-1:0]       valid;
  logic [SIZE-1:0]       ready;
  logic [SIZE*WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/zip_sync_buf.sv
// Joins SIZE input streams into one concatenated output stream.
// All inputs are consumed together, then held in a 2-entry output buffer.
module zip_sync_buf #(
  parameter int SIZE      = 2,
  parameter int DIN_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  zip_sync_buf_if.slave  din,
  zip_sync_buf_if.master dout
);
  localparam int OUT_W = SIZE * DIN_WIDTH;

  logic [OUT_W-1:0] r_mem [2];
  logic             r_wrPtr;
  logic             r_rdPtr;
  logic [1:0]       r_count;

  logic w_allValid;
  logic w_notFull;
  logic w_push;
  logic w_pop;

  // Readiness comes only from registered occupancy, so dout.ready never
  // reaches din.ready combinationally; rst gating covers the reset cycle.
  assign w_allValid = &din.valid;
  assign w_notFull  = (r_count != 2'd2);
  assign w_push     = w_allValid & w_notFull & ~rst;
  assign w_pop      = (r_count != 2'd0) & dout.ready[0];

  assign din.ready  = {SIZE{w_push}};
  assign dout.valid = (r_count != 2'd0);
  assign dout.data  = r_mem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wrPtr  <= 1'b0;
      r_rdPtr  <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= din.data;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_zip_sync_buf.sv
// Directed bench for zip_sync_buf with SIZE=2, DIN_WIDTH=8.
// Inputs change 1ns after each rising edge; outputs are sampled 1ns later.
module tb_zip_sync_buf;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  zip_sync_buf_if #(.SIZE(2), .WIDTH(8))  din ();
  zip_sync_buf_if #(.SIZE(1), .WIDTH(16)) dout ();

  zip_sync_buf #(.SIZE(2), .DIN_WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [15:0] data,
                               input logic outReady);
    din.valid     = valid;
    din.data      = data;
    dout.ready[0] = outReady;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [15:0] beat;
    logic [1:0]  readyBefore;
    checks   = 0;
    failures = 0;

    // Reset with all inputs valid: nothing acknowledged, outputs cleared.
    rst = 1'b1;
    applyStimulus(2'b11, 16'h2211, 1'b1);
    checkOutput("reset_ready_pre", 32'(din.ready), 32'h0);
    tick();
    checkOutput("reset_ready", 32'(din.ready), 32'h0);
    checkOutput("reset_valid", 32'(dout.valid), 32'h0);
    checkOutput("reset_data", 32'(dout.data), 32'h0);
    tick();
    checkOutput("reset_ready2", 32'(din.ready), 32'h0);
    checkOutput("reset_valid2", 32'(dout.valid), 32'h0);
    applyStimulus(2'b00, 16'h0000, 1'b1);
    rst = 1'b0;
    tick();
    checkOutput("post_reset_valid", 32'(dout.valid), 32'h0);
    checkOutput("post_reset_data", 32'(dout.data), 32'h0);

    // Single transfer.
    applyStimulus(2'b11, 16'h55AA, 1'b1);
    checkOutput("single_ready", 32'(din.ready), 32'h3);
    tick();
    applyStimulus(2'b00, 16'h0000, 1'b1);
    checkOutput("single_valid", 32'(dout.valid), 32'h1);
    checkOutput("single_data", 32'(dout.data), 32'h55AA);
    checkOutput("single_ready_idle", 32'(din.ready), 32'h0);
    tick();
    checkOutput("single_valid_drop", 32'(dout.valid), 32'h0);

    // Partial valid: only din[1] valid.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b10, 16'h0200, 1'b1);
      checkOutput("partial_ready", 32'(din.ready), 32'h0);
      tick();
      checkOutput("partial_valid", 32'(dout.valid), 32'h0);
    end
    applyStimulus(2'b11, 16'h0201, 1'b1);
    checkOutput("partial_join_ready", 32'(din.ready), 32'h3);
    tick();
    applyStimulus(2'b00, 16'h0000, 1'b1);
    checkOutput("partial_join_valid", 32'(dout.valid), 32'h1);
    checkOutput("partial_join_data", 32'(dout.data), 32'h0201);
    tick();
    checkOutput("partial_join_drop", 32'(dout.valid), 32'h0);

    // Backpressure fill to two entries, then drain in order.
    applyStimulus(2'b11, 16'h0101, 1'b0);
    checkOutput("bp_ready0", 32'(din.ready), 32'h3);
    tick();
    applyStimulus(2'b11, 16'h0202, 1'b0);
    checkOutput("bp_ready1", 32'(din.ready), 32'h3);
    tick();
    applyStimulus(2'b11, 16'h0303, 1'b0);
    checkOutput("bp_full_ready", 32'(din.ready), 32'h0);
    checkOutput("bp_full_data", 32'(dout.data), 32'h0101);
    tick();
    checkOutput("bp_hold_ready", 32'(din.ready), 32'h0);
    checkOutput("bp_hold_valid", 32'(dout.valid), 32'h1);
    checkOutput("bp_hold_data", 32'(dout.data), 32'h0101);
    applyStimulus(2'b11, 16'h0303, 1'b1);
    checkOutput("bp_first_pop_ready", 32'(din.ready), 32'h0);
    tick();
    checkOutput("bp_out1_data", 32'(dout.data), 32'h0202);
    checkOutput("bp_after_pop_ready", 32'(din.ready), 32'h3);
    tick();
    applyStimulus(2'b00, 16'h0000, 1'b1);
    checkOutput("bp_out2_valid", 32'(dout.valid), 32'h1);
    checkOutput("bp_out2_data", 32'(dout.data), 32'h0303);
    tick();
    checkOutput("bp_drained", 32'(dout.valid), 32'h0);

    // Full throughput with random data; dout.ready flipped to probe ready paths.
    for (int i = 0; i < 100; i++) begin
      beat = 16'($urandom);
      applyStimulus(2'b11, beat, 1'b0);
      readyBefore = din.ready;
      applyStimulus(2'b11, beat, 1'b1);
      checkOutput("tp_ready_indep", 32'(din.ready), 32'(readyBefore));
      checkOutput("tp_ready", 32'(din.ready), 32'h3);
      tick();
      checkOutput("tp_valid", 32'(dout.valid), 32'h1);
      checkOutput("tp_data", 32'(dout.data), 32'(beat));
    end
    applyStimulus(2'b00, 16'h0000, 1'b1);
    tick();
    checkOutput("tp_drained", 32'(dout.valid), 32'h0);

    // Reset while holding two entries.
    applyStimulus(2'b11, 16'h0A0A, 1'b0);
    tick();
    applyStimulus(2'b11, 16'h0B0B, 1'b0);
    tick();
    checkOutput("mid_full_ready", 32'(din.ready), 32'h0);
    rst = 1'b1;
    applyStimulus(2'b11, 16'h0C0C, 1'b0);
    checkOutput("mid_rst_ready", 32'(din.ready), 32'h0);
    tick();
    checkOutput("mid_rst_valid", 32'(dout.valid), 32'h0);
    checkOutput("mid_rst_data", 32'(dout.data), 32'h0);
    applyStimulus(2'b00, 16'h0000, 1'b1);
    rst = 1'b0;
    tick();
    checkOutput("mid_idle_valid", 32'(dout.valid), 32'h0);
    applyStimulus(2'b11, 16'h0D0D, 1'b1);
    tick();
    applyStimulus(2'b00, 16'h0000, 1'b1);
    checkOutput("mid_post_valid", 32'(dout.valid), 32'h1);
    checkOutput("mid_post_data", 32'(dout.data), 32'h0D0D);
    tick();
    checkOutput("mid_post_drop", 32'(dout.valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
